// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and multi-cycle multiply
// stalls, control-flow flushes, and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  WA3E,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  WA3W,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MulOpE,
  input  logic        PCWrPendingF,
  input  logic        BranchTakenD,
  input  logic        PCSrcW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MulBusyE,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {IDLE, BUSY, LAST} state_t;

  // BUSY covers the cycles between the accepting IDLE cycle and the final LAST cycle.
  localparam logic [2:0] CNT_INIT = (MUL_LAT > 2) ? 3'(MUL_LAT - 3) : 3'd0;

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic        mulstall;
  logic        ldrstall;
  logic [15:0] stall_count;

  // r15 is the PC and is never forwarded; Memory takes priority as the newer value.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteM && (WA3M == ra) && (ra != 4'd15))
      sel = 2'b10;
    else if (RegWriteW && (WA3W == ra) && (ra != 4'd15))
      sel = 2'b01;
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(RA1E);
  assign ForwardBE = fwd_sel(RA2E);
  assign ldrstall  = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mulstall   = 1'b0;
    case (state)
      IDLE: begin
        if (MulOpE && (MUL_LAT > 1)) begin
          mulstall = 1'b1;
          if (MUL_LAT > 2) begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = LAST;
          end
        end
      end
      BUSY: begin
        mulstall = 1'b1;
        if (cnt == 3'd0) begin
          state_next = LAST;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      LAST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A redirect in Writeback kills any multiply in flight.
    if (PCSrcW || !reset) begin
      mulstall   = 1'b0;
      state_next = IDLE;
      cnt_next   = 3'd0;
    end
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (mulstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = ldrstall || PCWrPendingF;
      StallD = ldrstall;
      FlushD = PCWrPendingF || PCSrcW || BranchTakenD;
      FlushE = ldrstall || BranchTakenD || PCSrcW;
    end
  end

  assign MulBusyE = mulstall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= 16'd0;
    end else if (StallF && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign StallCount = stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, multiply/flush/reset sequences,
// randomized run against a cycle-count reference model, counter saturation.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemtoRegE, MulOpE;
  logic        PCWrPendingF, BranchTakenD, PCSrcW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE;
  logic [15:0] StallCount;

  hazard_unit #(.MUL_LAT(3)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .MulOpE(MulOpE),
    .PCWrPendingF(PCWrPendingF), .BranchTakenD(BranchTakenD), .PCSrcW(PCSrcW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MulBusyE(MulBusyE), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  logic [10:0] outs;
  assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE};

  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwm, rww, mtr, pcwp, btd, pcsrc;
    logic [1:0] fae, fbe;
    logic sf, sd, se, fd, fe, fm;
  } vec_t;

  vec_t tbl [12];
  int vectors = 0;
  int miscompares = 0;
  int mrem;
  int mcnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemtoRegE, MulOpE} = '0;
    {PCWrPendingF, BranchTakenD, PCSrcW} = '0;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  function automatic logic [1:0] mfwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    logic [10:0] e;
    logic ld, ms, sf, sd, se, fd, fe, fm;
    int exp_cnt;
    logic busy_pat [6];

    //            ra1d  ra2d  ra1e  ra2e  wa3e  wa3m  wa3w  rwm rww mtr pcwp btd pcs fae fbe sf sd se fd fe fm
    tbl[0]  = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd7, 4'd3, 4'd3, 1, 1, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd7, 4'd3, 4'd3, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{4'd1, 4'd2, 4'd15, 4'd0, 4'd7, 4'd15, 4'd15, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{4'd1, 4'd2, 4'd9, 4'd6, 4'd7, 4'd6, 4'd9, 1, 1, 0, 0, 0, 0, 2'd1, 2'd2, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd5, 4'd1, 4'd1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 1, 1, 0, 0, 1, 0};
    tbl[5]  = '{4'd4, 4'd6, 4'd0, 4'd0, 4'd5, 4'd1, 4'd1, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd5, 4'd1, 4'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd7, 4'd1, 4'd1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 1, 0, 0, 1, 0, 0};
    tbl[8]  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd1, 4'd1, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0};
    tbl[9]  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd1, 4'd1, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0};
    tbl[10] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd5, 4'd1, 4'd1, 0, 0, 1, 0, 0, 1, 2'd0, 2'd0, 1, 1, 0, 1, 1, 0};
    tbl[11] = '{4'd0, 4'd0, 4'd4, 4'd15, 4'd7, 4'd8, 4'd4, 1, 1, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0};

    // Reset state, with a multiply requested while reset is held low.
    clear_inputs();
    MulOpE = 1'b1;
    #2;
    check("rst_busy", 16'(MulBusyE), 16'd0);
    check("rst_stalle", 16'(StallE), 16'd0);
    check("rst_flushm", 16'(FlushM), 16'd0);
    check("rst_count", StallCount, 16'd0);
    MulOpE = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Directed single-cycle vectors with the multiply FSM idle.
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} =
        {tbl[i].ra1d, tbl[i].ra2d, tbl[i].ra1e, tbl[i].ra2e, tbl[i].wa3e, tbl[i].wa3m, tbl[i].wa3w};
      {RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, BranchTakenD, PCSrcW} =
        {tbl[i].rwm, tbl[i].rww, tbl[i].mtr, tbl[i].pcwp, tbl[i].btd, tbl[i].pcsrc};
      MulOpE = 1'b0;
      #1;
      e = {tbl[i].fae, tbl[i].fbe, tbl[i].sf, tbl[i].sd, tbl[i].se, tbl[i].fd, tbl[i].fe, tbl[i].fm, 1'b0};
      check($sformatf("tbl%0d", i), 16'(outs), 16'(e));
      if (tbl[i].sf) exp_cnt++;
      tick();
    end
    check("tbl_count", StallCount, 16'(exp_cnt));

    // Back-to-back multiplies with a branch held: flushes are masked while busy.
    clear_inputs();
    busy_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      MulOpE = 1'b1;
      BranchTakenD = 1'b1;
      #1;
      check($sformatf("mul%0d_busy", i), 16'(MulBusyE), 16'(busy_pat[i]));
      check($sformatf("mul%0d_flushm", i), 16'(FlushM), 16'(busy_pat[i]));
      check($sformatf("mul%0d_stalle", i), 16'(StallE), 16'(busy_pat[i]));
      check($sformatf("mul%0d_flushe", i), 16'(FlushE), 16'(!busy_pat[i]));
      check($sformatf("mul%0d_flushd", i), 16'(FlushD), 16'(!busy_pat[i]));
      tick();
    end
    clear_inputs();
    #1;
    check("mul_after_idle", 16'(MulBusyE), 16'd0);
    tick();

    // Writeback redirect aborts a multiply in BUSY.
    MulOpE = 1'b1;
    #1;
    check("pcs_c1_busy", 16'(MulBusyE), 16'd1);
    tick();
    PCSrcW = 1'b1;
    #1;
    check("pcs_c2_busy", 16'(MulBusyE), 16'd0);
    check("pcs_c2_flushd", 16'(FlushD), 16'd1);
    check("pcs_c2_flushe", 16'(FlushE), 16'd1);
    check("pcs_c2_stalle", 16'(StallE), 16'd0);
    tick();
    PCSrcW = 1'b0;
    #1;
    check("pcs_c3_idle", 16'(MulBusyE), 16'd1);
    tick();
    MulOpE = 1'b0;
    #1;
    check("pcs_c4_busy", 16'(MulBusyE), 16'd1);
    tick();
    #1;
    check("pcs_c5_last", 16'(MulBusyE), 16'd0);
    tick();

    // Asynchronous reset in the middle of a multiply.
    MulOpE = 1'b1;
    #1;
    tick();
    MulOpE = 1'b0;
    #1;
    check("arst_pre_busy", 16'(MulBusyE), 16'd1);
    reset = 1'b0;
    #1;
    check("arst_busy", 16'(MulBusyE), 16'd0);
    check("arst_stalle", 16'(StallE), 16'd0);
    check("arst_flushm", 16'(FlushM), 16'd0);
    check("arst_count", StallCount, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    MulOpE = 1'b1;
    #1;
    check("arst_new_mul", 16'(MulBusyE), 16'd1);
    tick();
    MulOpE = 1'b0;
    #1;
    check("arst_new_busy", 16'(MulBusyE), 16'd1);
    tick();
    #1;
    check("arst_new_last", 16'(MulBusyE), 16'd0);

    // Randomized run against the reference model, starting from reset.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mrem = 0;
    mcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
      WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      MulOpE = ($urandom_range(0, 2) == 0);
      PCWrPendingF = ($urandom_range(0, 7) == 0);
      BranchTakenD = ($urandom_range(0, 7) == 0);
      PCSrcW = ($urandom_range(0, 11) == 0);
      #1;
      ld = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
      if (mrem == 0) ms = MulOpE && !PCSrcW;
      else ms = (mrem > 1) && !PCSrcW;
      if (ms) begin
        {sf, sd, se, fd, fe, fm} = 6'b111001;
      end else begin
        sf = ld || PCWrPendingF;
        sd = ld;
        se = 1'b0;
        fm = 1'b0;
        fd = PCWrPendingF || PCSrcW || BranchTakenD;
        fe = ld || BranchTakenD || PCSrcW;
      end
      e = {mfwd(RA1E), mfwd(RA2E), sf, sd, se, fd, fe, fm, ms};
      check($sformatf("rand%0d", n), 16'(outs), 16'(e));
      check($sformatf("rand%0d_cnt", n), StallCount, 16'(mcnt));
      if (sf && mcnt < 65535) mcnt++;
      if (PCSrcW) mrem = 0;
      else if (mrem > 0) mrem--;
      else if (MulOpE) mrem = 2;
    end

    // Counter saturation, then asynchronous clear between clock edges.
    tick();
    clear_inputs();
    PCWrPendingF = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("sat_count", StallCount, 16'hFFFF);
    #2;
    reset = 1'b0;
    #1;
    check("sat_async_clear", StallCount, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: total cycles a multiply occupies Execute, legal range 1..8.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports RA1D, RA2D, RA1E, RA2E, input, 4 each: source register numbers in Decode and Execute.
REQ-005 SHALL have ports WA3E, WA3M, WA3W, input, 4 each: destination register numbers in Execute, Memory and Writeback.
REQ-006 SHALL have ports RegWriteM, RegWriteW, MemtoRegE, MulOpE, input, 1 each: gated write enables, load in Execute, multiply in Execute.
REQ-007 SHALL have ports PCWrPendingF, BranchTakenD, PCSrcW, input, 1 each: PC write in flight, early branch taken, PC written in Writeback.
REQ-008 SHALL have ports ForwardAE, ForwardBE, output, 2 each: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-009 SHALL have ports StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE, output, 1 each.
REQ-010 SHALL have port StallCount, output, 16: saturating count of cycles with StallF=1.

Function
REQ-011 SHALL drive ForwardAE=10 when RegWriteM=1, WA3M=RA1E and RA1E!=15; else 01 when RegWriteW=1, WA3W=RA1E and RA1E!=15; else 00.
REQ-012 SHALL derive ForwardBE identically from RA2E.
REQ-013 SHALL compute ldrstall = MemtoRegE & ((RA1D=WA3E) | (RA2D=WA3E)).
REQ-014 SHALL implement a multiply FSM with states IDLE, BUSY and LAST, plus a 3-bit down-counter.
REQ-015 IDLE: when MulOpE=1 and MUL_LAT>1, SHALL assert mulstall that cycle and go to BUSY with counter=MUL_LAT-3 (MUL_LAT>2) or go to LAST (MUL_LAT=2); MUL_LAT=1 SHALL never leave IDLE.
REQ-016 BUSY: SHALL assert mulstall, decrement the counter, and go to LAST when the counter is 0.
REQ-017 LAST: SHALL deassert mulstall, ignore MulOpE, and go to IDLE; a multiply therefore occupies Execute exactly MUL_LAT cycles.
REQ-018 MulBusyE SHALL equal mulstall.
REQ-019 While mulstall=1: StallF=StallD=StallE=1, FlushM=1, FlushE=0, FlushD=0; ldrstall and BranchTakenD SHALL be masked.
REQ-020 Otherwise: StallF = ldrstall | PCWrPendingF; StallD = ldrstall; StallE=0; FlushM=0.
REQ-021 Otherwise: FlushD = PCWrPendingF | PCSrcW | BranchTakenD; FlushE = ldrstall | BranchTakenD.
REQ-022 PCSrcW=1 SHALL override everything: FSM to IDLE next cycle, mulstall=0 this cycle, FlushD=FlushE=1, StallE=0.
REQ-023 StallCount SHALL increment on each cycle with StallF=1 and hold at 16'hFFFF.
REQ-024 All outputs except StallCount SHALL be combinational from the inputs and FSM state.

Reset
REQ-025 On reset low, SHALL force FSM=IDLE, counter=0 and StallCount=0 immediately, independent of clk.
REQ-026 With reset low, mulstall SHALL be 0, and StallE and FlushM SHALL be 0; reset mid-multiply SHALL abandon the multiply.
REQ-027 SHALL leave reset on the first rising clk with reset high.

Verification
REQ-028 RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> 01; with RA1E=15 -> 00.
REQ-029 MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1 for one cycle; StallCount +1.
REQ-030 MUL_LAT=3, MulOpE=1 held three cycles -> MulBusyE=1,1,0; FlushM=1,1,0; state IDLE,BUSY,LAST, then IDLE.
REQ-031 Two back-to-back multiplies (MUL_LAT=3) -> MulBusyE pattern 1,1,0,1,1,0.
REQ-032 PCSrcW=1 during BUSY -> same cycle MulBusyE=0, FlushD=1, FlushE=1; next cycle state IDLE.
REQ-033 StallF held for 70000 cycles -> StallCount=16'hFFFF; reset low asynchronously -> StallCount=0 without a clk edge.
